// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the bus-side target.
// The master can reuse the line-level parts of this package.
package i2c_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam logic        RW_READ   = 1'b1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ACK_ADDR  = 4'd2,
        MEM       = 4'd3,
        ACK_MEM   = 4'd4,
        WRITE     = 4'd5,
        ACK_WRITE = 4'd6,
        READ      = 4'd7,
        WAIT_MACK = 4'd8,
        IGNORE    = 4'd9
    } target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and decodes SCL edges plus START/STOP conditions.
// START/STOP need the new SDA level held for two samples, so a one-clock SDA glitch is ignored.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic       sda_prev2;

    // Bus idles high, so every stage presets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            sda_prev2 <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_i};
            sda_sync  <= {sda_sync[0], sda_i};
            scl_prev  <= scl_sync[1];
            sda_prev  <= sda_sync[1];
            sda_prev2 <= sda_prev;
        end
    end

    assign sda        = sda_sync[1];
    assign scl_rise_c = scl_sync[1] & ~scl_prev;
    assign scl_fall_c = ~scl_sync[1] & scl_prev;
    assign start_c    = scl_sync[1] & scl_prev & sda_prev2 & ~sda_prev & ~sda_sync[1];
    assign stop_c     = scl_sync[1] & scl_prev & ~sda_prev2 & sda_prev & sda_sync[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: address + R/W, memory index, then data bytes against a byte register file.
// SDA is sampled on SCL rise and sda_oe only changes on SCL fall.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [7:0]  TARGET_ADDR = 8'h01,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned MEM_AW      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    output logic [3:0]        target_state
);

    logic sda, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_line_sync u_line_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda        (sda),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    target_state_t        state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [BYTE_BITS-1:0] shreg, shreg_n;
    logic                 rw, rw_n;
    logic [MEM_AW-1:0]    ptr, ptr_n;
    logic                 sda_oe_n, busy_n, we;
    logic [BYTE_BITS-1:0] mem [MEM_DEPTH];
    logic [BYTE_BITS-1:0] byte_in, rd_byte;
    logic [MEM_AW-1:0]    ptr_inc;

    assign byte_in      = {shreg[BYTE_BITS-2:0], sda};
    assign rd_byte      = mem[ptr];
    assign ptr_inc      = (ptr == MEM_AW'(MEM_DEPTH - 1)) ? '0 : ptr + MEM_AW'(1);
    assign dbg_data     = mem[dbg_addr];
    assign target_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            rw        <= rw_n;
            ptr       <= ptr_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_strobe <= we;
            if (we) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    // Single write port; dbg reads see the pre-write value in the write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[ptr] <= byte_in;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        rw_n     = rw;
        ptr_n    = ptr;
        sda_oe_n = sda_oe;
        busy_n   = busy;
        we       = 1'b0;
        if (stop_c) begin
            state_n  = IDLE;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_c) begin
            state_n  = ADDR;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: if (scl_rise_c) begin
                    if (cnt == 4'(BYTE_BITS)) begin
                        cnt_n = '0;
                        if (shreg == TARGET_ADDR) begin
                            state_n = ACK_ADDR;
                            rw_n    = sda;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                    end
                end
                MEM: if (scl_rise_c) begin
                    if (cnt == 4'(BYTE_BITS - 1)) begin
                        cnt_n = '0;
                        if ({1'b0, byte_in} < 9'(MEM_DEPTH)) begin
                            state_n = ACK_MEM;
                            ptr_n   = MEM_AW'(byte_in);
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                    end
                end
                WRITE: if (scl_rise_c) begin
                    if (cnt == 4'(BYTE_BITS - 1)) begin
                        we      = 1'b1;
                        cnt_n   = '0;
                        state_n = ACK_WRITE;
                    end else begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 4'd1;
                    end
                end
                // cnt=0: first fall drives the ACK low; cnt=1: next fall ends the slot.
                ACK_ADDR, ACK_MEM, ACK_WRITE: if (scl_fall_c) begin
                    if (cnt == 4'd0) begin
                        sda_oe_n = 1'b1;
                        cnt_n    = 4'd1;
                    end else begin
                        cnt_n    = '0;
                        sda_oe_n = 1'b0;
                        if (state == ACK_ADDR) begin
                            state_n = MEM;
                        end else if (state == ACK_WRITE) begin
                            state_n = WRITE;
                            ptr_n   = ptr_inc;
                        end else if (rw == RW_READ) begin
                            state_n  = READ;
                            sda_oe_n = ~rd_byte[BYTE_BITS-1];
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
                // cnt counts bits already clocked out; the next fall drives bit 7-cnt.
                READ: begin
                    if (scl_rise_c) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall_c) begin
                        if (cnt == 4'(BYTE_BITS)) begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            state_n  = WAIT_MACK;
                        end else begin
                            sda_oe_n = ~rd_byte[3'(BYTE_BITS - 1) - cnt[2:0]];
                        end
                    end
                end
                WAIT_MACK: if (scl_rise_c) begin
                    cnt_n = '0;
                    if (!sda) begin
                        state_n = READ;
                        ptr_n   = ptr_inc;
                    end else begin
                        state_n = IGNORE;
                        busy_n  = 1'b0;
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                    busy_n   = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master at clk/8 driving frames from a vector table,
// plus hand-written sequences for STOP mid-byte and reset mid-read.
module tb_i2c_target;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_oe, busy, wr_strobe;
    logic [5:0] wr_addr, dbg_addr;
    logic [7:0] wr_data, dbg_data;
    logic [3:0] target_state;
    wire        sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(8'h01), .MEM_DEPTH(64), .MEM_AW(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_i        (scl),
        .sda_i        (sda_bus),
        .sda_oe       (sda_oe),
        .busy         (busy),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .target_state (target_state)
    );

    int         checks = 0;
    int         failures = 0;
    int         strobe_cnt = 0;
    int         oe_cnt = 0;
    logic [5:0] last_waddr = '0;
    logic [7:0] last_wdata = '0;

    always @(posedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_waddr = wr_addr;
            last_wdata = wr_data;
        end
        if (sda_oe === 1'b1) oe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL pulse: SDA set mid-low, bus sampled mid-high, ends with SCL falling.
    task automatic send_bit(input logic b, output logic r);
        tick(2); sda_m = b;
        tick(2); scl = 1'b1;
        tick(2); r = sda_bus;
        tick(2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], t);
            r[i] = t;
        end
    endtask

    task automatic start_cond();
        tick(4); sda_m = 1'b0;
        tick(4); scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(2); sda_m = 1'b0;
        tick(2); scl = 1'b1;
        tick(4); sda_m = 1'b1;
        tick(6);
    endtask

    task automatic check_dbg(input string name, input logic [5:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        tick(1);
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    typedef struct {
        logic [7:0]    dev;
        logic          rd;
        logic [7:0]    mem;
        int            n;
        logic [7:0]    d0;
        logic [7:0]    d1;
        logic          aack;
        logic          mack;
        target_state_t st;
        int            strobes;
        logic [5:0]    waddr;
        logic [7:0]    wdata;
        logic [5:0]    ci0;
        logic [7:0]    cv0;
        logic [5:0]    ci1;
        logic [7:0]    cv1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       a;
        logic [7:0] r;
        logic [7:0] exp_b;
        int         s0, o0;

        vecs[0] = '{8'h01, 1'b0, 8'h05, 1, 8'hA5, 8'h00, 1'b1, 1'b1, WRITE,  1, 6'd5, 8'hA5, 6'd5,  8'hA5, 6'd4,  8'h00};
        vecs[1] = '{8'h01, 1'b0, 8'h05, 1, 8'h3C, 8'h00, 1'b1, 1'b1, WRITE,  1, 6'd5, 8'h3C, 6'd5,  8'h3C, 6'd6,  8'h00};
        vecs[2] = '{8'h01, 1'b1, 8'h05, 1, 8'h3C, 8'h00, 1'b1, 1'b1, IGNORE, 0, 6'd0, 8'h00, 6'd5,  8'h3C, 6'd4,  8'h00};
        vecs[3] = '{8'h02, 1'b0, 8'h05, 1, 8'h77, 8'h00, 1'b0, 1'b0, IGNORE, 0, 6'd0, 8'h00, 6'd5,  8'h3C, 6'd4,  8'h00};
        vecs[4] = '{8'h01, 1'b0, 8'd63, 2, 8'h11, 8'h22, 1'b1, 1'b1, WRITE,  2, 6'd0, 8'h22, 6'd63, 8'h11, 6'd0,  8'h22};
        vecs[5] = '{8'h01, 1'b0, 8'd64, 1, 8'h55, 8'h00, 1'b1, 1'b0, IGNORE, 0, 6'd0, 8'h00, 6'd0,  8'h22, 6'd63, 8'h11};
        vecs[6] = '{8'h01, 1'b1, 8'd63, 2, 8'h11, 8'h22, 1'b1, 1'b1, IGNORE, 0, 6'd0, 8'h00, 6'd63, 8'h11, 6'd0,  8'h22};

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; dbg_addr = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_state",   32'(target_state), 32'(IDLE));
        check("rst_sda_oe",  32'(sda_oe), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_wr_strb", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check_dbg("rst_reg5", 6'd5, 8'h00);

        for (int i = 0; i < 7; i++) begin
            s0 = strobe_cnt;
            o0 = oe_cnt;
            start_cond();
            send_byte(vecs[i].dev, r);
            send_bit(vecs[i].rd, a);
            send_bit(1'b1, a);
            check($sformatf("v%0d_ack_addr", i), 32'(a), 32'(!vecs[i].aack));
            send_byte(vecs[i].mem, r);
            send_bit(1'b1, a);
            check($sformatf("v%0d_ack_mem", i), 32'(a), 32'(!vecs[i].mack));
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_b = (k == 0) ? vecs[i].d0 : vecs[i].d1;
                if (!vecs[i].rd) begin
                    send_byte(exp_b, r);
                    send_bit(1'b1, a);
                    check($sformatf("v%0d_ack_data%0d", i, k), 32'(a), 32'(!vecs[i].mack));
                end else begin
                    send_byte(8'hFF, r);
                    check($sformatf("v%0d_rd_data%0d", i, k), 32'(r), 32'(exp_b));
                    send_bit(k == vecs[i].n - 1, a);
                end
            end
            tick(4);
            check($sformatf("v%0d_state", i), 32'(target_state), 32'(vecs[i].st));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].st != IGNORE));
            stop_cond();
            check($sformatf("v%0d_stop_state", i), 32'(target_state), 32'(IDLE));
            check($sformatf("v%0d_stop_busy", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'(vecs[i].strobes));
            if (vecs[i].strobes > 0) begin
                check($sformatf("v%0d_wr_addr", i), 32'(last_waddr), 32'(vecs[i].waddr));
                check($sformatf("v%0d_wr_data", i), 32'(last_wdata), 32'(vecs[i].wdata));
            end
            if (!vecs[i].aack)
                check($sformatf("v%0d_oe_quiet", i), 32'(oe_cnt - o0), 32'd0);
            check_dbg($sformatf("v%0d_reg_a", i), vecs[i].ci0, vecs[i].cv0);
            check_dbg($sformatf("v%0d_reg_b", i), vecs[i].ci1, vecs[i].cv1);
        end

        // STOP after four data bits of a write: no byte may be committed.
        s0 = strobe_cnt;
        start_cond();
        send_byte(8'h01, r);
        send_bit(1'b0, a);
        send_bit(1'b1, a);
        send_byte(8'd10, r);
        send_bit(1'b1, a);
        send_bit(1'b1, a); send_bit(1'b0, a); send_bit(1'b1, a); send_bit(1'b0, a);
        check("midw_state", 32'(target_state), 32'(WRITE));
        stop_cond();
        check("midw_stop_state", 32'(target_state), 32'(IDLE));
        check("midw_strobes", 32'(strobe_cnt - s0), 32'd0);
        check_dbg("midw_reg10", 6'd10, 8'h00);

        // Reset while reg[0]=8'h22 is being read, with bit 3 (a 0) on the bus.
        start_cond();
        send_byte(8'h01, r);
        send_bit(1'b1, a);
        send_bit(1'b1, a);
        send_byte(8'h00, r);
        send_bit(1'b1, a);
        for (int k = 7; k >= 4; k--) begin
            send_bit(1'b1, a);
            r[k] = a;
        end
        check("midr_bits", 32'(r[7:4]), 32'h2);
        tick(3);
        check("midr_state", 32'(target_state), 32'(READ));
        check("midr_oe_bit3", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check("midr_rst_oe", 32'(sda_oe), 32'd0);
        check("midr_rst_state", 32'(target_state), 32'(IDLE));
        check("midr_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0; scl = 1'b1; sda_m = 1'b1;
        tick(2);
        for (int k = 0; k < 64; k++)
            check_dbg($sformatf("midr_reg%0d", k), 6'(k), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) for the team's APB-to-I2C bridge; the bus-side counterpart of the existing I2C master.
- Oversamples SCL and SDA on the system clock and decodes START and STOP.
- Decodes the frame: address + R/W, memory address, then data.
- Serves reads and writes from an internal byte-wide register file, driving SDA open-drain for ACKs and read data.

Parameters:
- TARGET_ADDR, 8'h01, 8-bit target address matched in the address phase.
- MEM_DEPTH, 64, number of 8-bit registers; valid memory addresses are 0..MEM_DEPTH-1.
- MEM_AW, 6, register index width, equal to clog2(MEM_DEPTH).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- scl_i  input  1  raw SCL from bus, asynchronous.
- sda_i  input  1  raw SDA from bus, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- busy  output  1  high from START (address match) until STOP or IGNORE.
- wr_strobe  output  1  one-clk pulse when a register is written.
- wr_addr  output  MEM_AW  index written, valid with wr_strobe.
- wr_data  output  8  byte written, valid with wr_strobe.
- dbg_addr  input  MEM_AW  bench/host read index.
- dbg_data  output  8  combinational read of reg[dbg_addr].
- target_state  output  4  current FSM state, for test visibility.

Behaviour:
- Reset (synchronous, active-high): state IDLE; sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0; all registers cleared to 0; synchronizers preset to 1.
  - Reset mid-transfer aborts immediately and releases SDA the following cycle.
- Input conditioning: 2-flop synchronizer per line, then a registered previous value.
  - scl_rise = 0→1 and scl_fall = 1→0 on synced SCL.
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
- Latency:
  - sda_oe updates 3 clk after the SCL falling edge at the pin.
  - With the master's SCL at clk/8 (4 clk half-period), SDA is stable before the next rising edge.
- Timing rules: sample SDA only on scl_rise; change sda_oe only on scl_fall.
- Frame, MSB first: 8 address bits, R/W bit (1 = read), ACK, 8 memory-address bits, ACK, then data bytes each followed by ACK.
- States: IDLE, ADDR, ACK_ADDR, MEM, ACK_MEM, WRITE, ACK_WRITE, READ, WAIT_MACK, IGNORE.
- Bit counter: 4-bit, cleared on state entry; a byte completes when the count reaches 8.
- Transitions:
  - IDLE -START→ ADDR.
  - ADDR: after 9 bits, address == TARGET_ADDR → ACK_ADDR and latch R/W; otherwise → IGNORE with sda_oe never asserted.
  - ACK_ADDR: assert sda_oe on the scl_fall after bit 9, release on the next scl_fall → MEM.
  - MEM: after 8 bits, index < MEM_DEPTH → ACK_MEM; otherwise NACK (SDA released) → IGNORE.
  - ACK_MEM: drive ACK low; → WRITE if W, → READ if R.
    - For READ, the first data bit is driven on the scl_fall that ends the ACK.
  - WRITE: after 8 bits, store the byte to reg[ptr], pulse wr_strobe for 1 clk → ACK_WRITE.
  - ACK_WRITE: drive ACK; ptr = (ptr+1) mod MEM_DEPTH (wrap) → WRITE for further bytes.
  - READ: drive reg[ptr] MSB first, where 0 bits set sda_oe=1 and 1 bits set sda_oe=0. After 8 bits, release SDA → WAIT_MACK.
  - WAIT_MACK: sample on scl_rise.
    - SDA=0 (master ACK): ptr wraps +1 → READ.
    - SDA=1 (NACK): → IGNORE.
  - IGNORE: sda_oe=0, busy=0; wait for START or STOP.
- Bus conditions:
  - STOP in any state → IDLE, sda_oe=0 in the same cycle it is detected.
  - START (repeated) in any state → ADDR, counter cleared, ptr retained.
  - START and scl edge detected in the same clk: START wins.
- Register file: one write port (FSM only); read used by both the FSM and dbg_data.
  - A write on the same clk as a dbg read of the same index returns the old value.
- SDA glitch while SCL high that is not a clean START/STOP is ignored; START/STOP detection requires 1 clk of stable level.

Decomposition:
- Shared package i2c_pkg holds:
  - the target state enum (4-bit, encodings fixed as listed, IDLE=0);
  - BYTE_BITS=8;
  - RW_READ=1'b1.
- One natural sub-module: i2c_line_sync (synchronizers, edge detect, START/STOP pulses); reusable by the master.

Test Plan:
- Write: START, addr 8'h01, W, mem 8'h05, data 8'hA5, STOP → ACKs at the three ACK slots, wr_strobe with wr_addr=5 and wr_data=A5, dbg_data[5]=8'hA5.
- Read: preload reg[5]=8'h3C, then START, addr 8'h01, R, mem 8'h05 → SDA carries 0,0,1,1,1,1,0,0; master NACK; STOP → state IDLE, busy=0.
- Address mismatch: addr 8'h02 → sda_oe stays 0 for the whole frame, state IGNORE, no wr_strobe.
- Burst write with wrap: mem 8'd63, data 8'h11 then 8'h22 → reg[63]=11, reg[0]=22.
- Out-of-range mem 8'd64 → NACK (SDA high at slot), IGNORE, no register change.
- Reset mid-READ on bit 3 → sda_oe=0 the next clk, state IDLE, all registers 0.
- STOP mid-WRITE after 4 bits → IDLE, no wr_strobe.
